// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side bundle for the branch-prediction controller: fetch lookup,
// F/D/E pipeline control, Execute resolution, and prediction/redirect results.
interface branch_predict_ctrl_if;
    logic [31:0] PCF;
    logic [6:0]  OpcodeF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        Eval_branch;
    logic        PCSrcE;
    logic        Prediction_Correct;
    logic        Predict_branchF;
    logic        Predict_branchE;
    logic        MispredictE;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    // Core pipeline / hazard unit side
    modport master (
        output PCF, OpcodeF, StallD, FlushD, FlushE,
               Eval_branch, PCSrcE, Prediction_Correct,
        input  Predict_branchF, Predict_branchE, MispredictE,
               BranchCount, MispredCount
    );

    // Predictor side
    modport slave (
        input  PCF, OpcodeF, StallD, FlushD, FlushE,
               Eval_branch, PCSrcE, Prediction_Correct,
        output Predict_branchF, Predict_branchE, MispredictE,
               BranchCount, MispredCount
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor for the 5-stage core, trained in Execute.
// Optional resolved-branch / misprediction statistics are enabled with BPRED_STATS_EN.
module branch_predict_ctrl #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_ctrl_if.slave bus
);

    localparam int         ENTRIES    = 1 << INDEX_BITS;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                  valid;
        logic                  pred;
        logic [INDEX_BITS-1:0] idx;
    } stage_t;

    function automatic ctr_e train(input ctr_e c, input logic taken);
        ctr_e n = c;
        if (taken && c != ST)
            n = ctr_e'(c + 2'd1);
        else if (!taken && c != SNT)
            n = ctr_e'(c - 2'd1);
        return n;
    endfunction

    ctr_e                  ctr_table [ENTRIES];
    stage_t                d_q;
    stage_t                e_q;
    logic [INDEX_BITS-1:0] idx_f;
    logic                  is_branch_f;
    logic                  pred_f;
    logic                  update;
    logic                  unused_pc;

    // Fetch lookup reads the registered table, so a same-cycle update is not visible yet.
    assign idx_f       = bus.PCF[INDEX_BITS+1:2];
    assign is_branch_f = (bus.OpcodeF == OPC_BRANCH);
    assign pred_f      = is_branch_f & ctr_table[idx_f][1];
    assign unused_pc   = ^{bus.PCF[31:INDEX_BITS+2], bus.PCF[1:0]};

    assign update      = bus.Eval_branch & e_q.valid;

    assign bus.Predict_branchF = pred_f;
    assign bus.Predict_branchE = e_q.pred & e_q.valid;
    assign bus.MispredictE     = update & ~bus.Prediction_Correct;

    // NOTE: every entry is reset here, so this array is built from flops rather than
    // a RAM macro; a RAM cannot be cleared in one asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_table[i] <= ctr_e'(INIT_STATE);
        end else if (update) begin
            ctr_table[e_q.idx] <= train(ctr_table[e_q.idx], bus.PCSrcE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the D->E copy sees the
    // old D value, exactly like the pipeline registers it shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            e_q <= '0;
        end else begin
            if (bus.FlushD)
                d_q <= '0;
            else if (!bus.StallD)
                d_q <= '{valid: is_branch_f, pred: pred_f, idx: idx_f};

            e_q <= bus.FlushE ? '0 : d_q;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (update && branch_count != '1)
                branch_count <= branch_count + 32'd1;
            if (bus.MispredictE && mispred_count != '1)
                mispred_count <= mispred_count + 32'd1;
        end
    end

    assign bus.BranchCount  = branch_count;
    assign bus.MispredCount = mispred_count;
`else
    assign bus.BranchCount  = 32'h0;
    assign bus.MispredCount = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, hand sequences,
// and randomized traffic against a behavioural predictor model.
module tb_branch_predict_ctrl;

    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [6:0] OPC_R = 7'b0110011;
`ifdef BPRED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_ctrl_if bus();

    branch_predict_ctrl #(.INDEX_BITS(6), .INIT_STATE(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] pcf, input logic [6:0] opc, input logic stall,
                         input logic fd, input logic fe, input logic ev, input logic tk,
                         input logic co);
        bus.PCF                = pcf;
        bus.OpcodeF            = opc;
        bus.StallD             = stall;
        bus.FlushD             = fd;
        bus.FlushE             = fe;
        bus.Eval_branch        = ev;
        bus.PCSrcE             = tk;
        bus.Prediction_Correct = co;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(32'h40, OPC_B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset_predE", {31'b0, bus.Predict_branchE}, 32'd0);
        check("reset_mispred", {31'b0, bus.MispredictE}, 32'd0);
        check("reset_predF", {31'b0, bus.Predict_branchF}, 32'd0);
        check("reset_bcount", bus.BranchCount, 32'd0);
        check("reset_mcount", bus.MispredCount, 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pcf;
        logic [6:0]  opc;
        logic        stall, fd, fe, ev, tk, co;
        logic        exp_f, exp_e, exp_m;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] opc, input logic stall, input logic fd,
                                input logic fe, input logic ev, input logic tk, input logic co,
                                input logic f, input logic e, input logic m);
        vec_t v;
        v.pcf = 32'h40; v.opc = opc; v.stall = stall; v.fd = fd; v.fe = fe;
        v.ev = ev; v.tk = tk; v.co = co; v.exp_f = f; v.exp_e = e; v.exp_m = m;
        return v;
    endfunction

    // Behavioural reference: counters as integers, pipeline stages as records.
    typedef struct { bit v; bit p; int idx; } mstage_t;
    int      m_cnt [64];
    mstage_t m_d, m_e;
    longint  m_br, m_mis;

    function automatic void model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 1;
        m_d = '{0, 0, 0};
        m_e = '{0, 0, 0};
        m_br = 0;
        m_mis = 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[19];
        vecs[0]  = mk(OPC_B, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(OPC_B, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(OPC_B, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // 01 -> 10
        vecs[3]  = mk(OPC_B, 0, 0, 0, 1, 1, 0, 1, 0, 1);  // 10 -> 11
        vecs[4]  = mk(OPC_B, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(OPC_R, 1, 0, 0, 1, 1, 1, 0, 1, 0);  // non-branch, stalled D
        vecs[6]  = mk(OPC_B, 0, 0, 0, 1, 1, 1, 1, 1, 0);
        vecs[7]  = mk(OPC_B, 0, 0, 0, 1, 1, 1, 1, 1, 0);  // stays 11
        vecs[8]  = mk(OPC_B, 0, 0, 0, 1, 0, 0, 1, 1, 1);  // -> 10
        vecs[9]  = mk(OPC_B, 0, 0, 0, 1, 0, 0, 1, 1, 1);  // -> 01
        vecs[10] = mk(OPC_B, 0, 0, 0, 1, 0, 0, 0, 1, 1);  // -> 00
        vecs[11] = mk(OPC_B, 0, 0, 0, 1, 0, 0, 0, 1, 1);  // stays 00
        vecs[12] = mk(OPC_B, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // flush beats stall
        vecs[13] = mk(OPC_B, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        vecs[14] = mk(OPC_B, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // flushed slot: ignored
        vecs[15] = mk(OPC_B, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // flush E with branch in D
        vecs[16] = mk(OPC_R, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // ignored
        vecs[17] = mk(OPC_R, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(OPC_B, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // still 00

        do_reset();

        for (int i = 0; i < 64; i++) begin
            apply(i * 4, OPC_B, 0, 0, 0, 0, 0, 0);
            check($sformatf("init_entry_%0d", i), {31'b0, bus.Predict_branchF}, 32'd0);
        end
        tick();
        do_reset();

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].pcf, vecs[i].opc, vecs[i].stall, vecs[i].fd, vecs[i].fe,
                  vecs[i].ev, vecs[i].tk, vecs[i].co);
            check($sformatf("vec%0d_predF", i), {31'b0, bus.Predict_branchF}, {31'b0, vecs[i].exp_f});
            check($sformatf("vec%0d_predE", i), {31'b0, bus.Predict_branchE}, {31'b0, vecs[i].exp_e});
            check($sformatf("vec%0d_mispred", i), {31'b0, bus.MispredictE}, {31'b0, vecs[i].exp_m});
            tick();
        end
        apply(32'h40, OPC_R, 0, 0, 0, 0, 0, 0);
        check("vec_bcount", bus.BranchCount, STATS ? 32'd10 : 32'd0);
        check("vec_mcount", bus.MispredCount, STATS ? 32'd6 : 32'd0);

        // Same-index collision at idx 5, then a predicted-taken mispredict.
        do_reset();
        apply(32'h14, OPC_B, 0, 0, 0, 0, 0, 0); tick();
        apply(32'h14, OPC_B, 0, 0, 0, 0, 0, 0); tick();
        apply(32'h14, OPC_B, 0, 0, 0, 1, 1, 0);
        check("coll_predF_same", {31'b0, bus.Predict_branchF}, 32'd0);
        check("coll_mispred", {31'b0, bus.MispredictE}, 32'd1);
        tick();
        apply(32'h14, OPC_B, 0, 0, 0, 0, 0, 0);
        check("coll_predF_next", {31'b0, bus.Predict_branchF}, 32'd1);
        check("coll_bcount", bus.BranchCount, STATS ? 32'd1 : 32'd0);
        check("coll_mcount", bus.MispredCount, STATS ? 32'd1 : 32'd0);
        tick();
        apply(32'h14, OPC_B, 0, 0, 0, 0, 0, 0); tick();
        apply(32'h14, OPC_B, 0, 0, 0, 1, 0, 0);
        check("mp_predE", {31'b0, bus.Predict_branchE}, 32'd1);
        check("mp_mispred", {31'b0, bus.MispredictE}, 32'd1);
        tick();
        apply(32'h14, OPC_B, 0, 0, 0, 0, 0, 0);
        check("mp_predF_dec", {31'b0, bus.Predict_branchF}, 32'd0);
        check("mp_bcount", bus.BranchCount, STATS ? 32'd2 : 32'd0);
        check("mp_mcount", bus.MispredCount, STATS ? 32'd2 : 32'd0);
        tick();

        // Randomized traffic against the model, with one reset mid-stream.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pcf;
            logic [6:0]  opc;
            logic        stall, fd, fe, ev, tk, co;
            int          idx;
            bit          br, exp_f, exp_e, exp_m;
            mstage_t     new_d, new_e;

            if (n == 1500) begin
                do_reset();
                model_reset();
            end

            idx   = ($urandom_range(0, 7) * 9) % 64;
            pcf   = ($urandom() & 32'hFFFF_FF03) | (idx << 2);
            opc   = ($urandom_range(0, 3) != 0) ? OPC_B : 7'($urandom_range(0, 127));
            stall = ($urandom_range(0, 7) == 0);
            fd    = ($urandom_range(0, 9) == 0);
            fe    = ($urandom_range(0, 9) == 0);
            ev    = 1'($urandom_range(0, 1));
            tk    = 1'($urandom_range(0, 1));
            co    = ($urandom_range(0, 3) != 0) ? (m_e.p == tk) : 1'($urandom_range(0, 1));

            br    = (opc == OPC_B);
            exp_f = br && (m_cnt[idx] >= 2);
            exp_e = m_e.v && m_e.p;
            exp_m = ev && m_e.v && !co;

            apply(pcf, opc, stall, fd, fe, ev, tk, co);
            check($sformatf("rnd%0d_predF", n), {31'b0, bus.Predict_branchF}, {31'b0, exp_f});
            check($sformatf("rnd%0d_predE", n), {31'b0, bus.Predict_branchE}, {31'b0, exp_e});
            check($sformatf("rnd%0d_mispred", n), {31'b0, bus.MispredictE}, {31'b0, exp_m});
            check($sformatf("rnd%0d_bcount", n), bus.BranchCount, STATS ? 32'(m_br) : 32'd0);
            check($sformatf("rnd%0d_mcount", n), bus.MispredCount, STATS ? 32'(m_mis) : 32'd0);
            tick();

            if (ev && m_e.v) begin
                m_cnt[m_e.idx] = tk ? ((m_cnt[m_e.idx] == 3) ? 3 : m_cnt[m_e.idx] + 1)
                                    : ((m_cnt[m_e.idx] == 0) ? 0 : m_cnt[m_e.idx] - 1);
                m_br++;
                if (!co) m_mis++;
            end
            new_e = fe ? '{0, 0, 0} : m_d;
            if (fd)          new_d = '{0, 0, 0};
            else if (stall)  new_d = m_d;
            else             new_d = '{br, exp_f, idx};
            m_e = new_e;
            m_d = new_d;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch-prediction controller for the 5-stage core.
- Holds a table of 2-bit saturating counters indexed by fetch PC and issues a taken/not-taken prediction in Fetch.
- Carries the prediction and its table index through Decode into Execute, where it drives Predict_branchE into the execute-stage predict handler.
- On branch resolution in Execute it trains the table and raises the mispredict redirect/flush request.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries, index = PCF[INDEX_BITS+1:2]).
- INIT_STATE, 2'b01, counter value loaded into every entry on reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- PCF  input  32  fetch-stage PC
- OpcodeF  input  7  InstrF[6:0] of the fetched instruction
- StallD  input  1  hold the F->D prediction register
- FlushD  input  1  invalidate the F->D prediction register
- FlushE  input  1  invalidate the D->E prediction register
- Eval_branch  input  1  Execute is resolving a conditional branch this cycle
- PCSrcE  input  1  actual branch outcome in Execute (1 = taken)
- Prediction_Correct  input  1  Execute-stage compare of prediction vs outcome
- Predict_branchF  output  1  prediction for the instruction at PCF
- Predict_branchE  output  1  prediction carried with the instruction now in Execute
- MispredictE  output  1  redirect/flush request to the hazard unit
- BranchCount  output  32  resolved-branch count (optional feature)
- MispredCount  output  32  misprediction count (optional feature)

Behaviour:
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Predict taken iff bit[1]=1.
- Fetch (combinational, 0 latency):
  - idxF = PCF[INDEX_BITS+1:2].
  - Predict_branchF = (OpcodeF==7'b1100011) & table[idxF][1].
  - Non-branch opcodes always give 0.
- F->D register {validD, predD, idxD}, on clk edge:
  - FlushD: all fields cleared to 0. FlushD wins over StallD.
  - Else StallD: hold.
  - Else load {OpcodeF==B-type, Predict_branchF, idxF}.
- D->E register {validE, predE, idxE}, on clk edge:
  - FlushE: cleared. Else load from the D register.
  - There is no E stall.
- Predict_branchE = predE & validE.
- Update fires when Eval_branch & validE, at the clock edge:
  - table[idxE] increments (saturate at 11) if PCSrcE, otherwise decrements (saturate at 00).
  - Eval_branch with validE=0 is ignored: no update, no mispredict.
- Read-during-write: if idxF==idxE in the update cycle, Predict_branchF uses the pre-update value. The new value is visible from the next cycle.
- MispredictE = Eval_branch & validE & ~Prediction_Correct.
  - Combinational, same cycle as resolution.
  - The table update still happens in that same cycle.
  - The hazard unit converts it to FlushD/FlushE. The block does not self-flush beyond honouring those inputs.
- Reset (async):
  - Every table entry = INIT_STATE.
  - validD/predD/idxD/validE/predE/idxE = 0.
  - Predict_branchE = 0, MispredictE = 0, counters = 0.
  - Predict_branchF follows the table immediately (0 for INIT_STATE=01).
  - Reset mid-operation discards all in-flight predictions and training.
- Aliasing: PCs sharing index bits share one entry. This is intentional; there are no tags.

Optional Feature:
Macro BPRED_STATS_EN.
- Defined:
  - BranchCount increments on every valid update.
  - MispredCount increments whenever MispredictE=1.
  - Both are 32-bit, saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both outputs tied to 32'h0 and no counter flops are instantiated.

Test Plan:
- Reset, then PCF=0x40 with OpcodeF=1100011 -> Predict_branchF=0. All 64 entries read 01.
- Branch at PC 0x40 (idx 16) resolved taken twice with Eval_branch=1, validE=1 -> entry 16 goes 01->10->11. Next fetch of 0x40 as B-type -> Predict_branchF=1. The same PC with OpcodeF=0110011 -> 0.
- Saturation: 3 further taken updates at idx 16 -> stays 11. Then 4 not-taken -> 10,01,00,00. Predict_branchF=0 after the 2nd not-taken.
- Mispredict: predE=1, validE=1, Eval_branch=1, PCSrcE=0, Prediction_Correct=0 -> MispredictE=1 that cycle and entry decremented. With BPRED_STATS_EN -> MispredCount=1, BranchCount=1.
- Flush/stall ordering:
  - FlushD=1 and StallD=1 together -> validD=0 next edge.
  - FlushE while a branch sits in D -> a subsequent Eval_branch=1 gives no update and MispredictE=0.
- Same-index collision: update idx 5 (01->10) while PCF maps to idx 5 -> Predict_branchF=0 in that cycle, 1 in the next cycle.
